sync_n_entry_fifo: RTL and testbench

Single-clock, parametrised FIFO that succeeds the fixed 2-entry push/full, pop/empty FIFO. It keeps the same handshake semantics and adds:
- configurable data width and depth;
- occupancy count and almost-full/almost-empty thresholds;
- overflow/underflow error pulses;
- selectable read mode: first-word-fall-through or registered.

It sits between a single-domain producer and consumer, as the default buffering element wherever no clock crossing is needed.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/sync_n_entry_fifo_if.sv | 32 +++
 rtl/fifo_ram.sv | 26 ++
 rtl/sync_n_entry_fifo.sv | 118 +++++++++++
 tb/tb_sync_n_entry_fifo.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised single-clock FIFO family:
// occupancy-width sizing, explicit pointer wrap and the push/pop operation code.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Width that can hold every occupancy 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wraps from depth-1 back to 0, so a depth that is not a power of two
    // never visits an unused storage slot.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_n_entry_fifo_if.sv
// Producer/consumer side bus of sync_n_entry_fifo: handshake, data, flags and error pulses.
interface sync_n_entry_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             push;
    logic [WIDTH-1:0] wdata;
    logic             full;
    logic             pop;
    logic [WIDTH-1:0] rdata;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, wdata, pop,
        input  full, rdata, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  push, wdata, pop,
        output full, rdata, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers and count define which words are
    // valid, and leaving the array unreset lets it map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_n_entry_fifo.sv
// Parametrised single-clock FIFO: pointers, occupancy count, registered flags,
// overflow/underflow pulses and an optional registered read port (FWFT=0).
module sync_n_entry_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 1
) (
    input  logic                clk,
    input  logic                reset,
    sync_n_entry_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             almost_full_q;
    logic             almost_empty_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             push_ok;
    logic             pop_ok;
    fifo_op_e         op;
    logic [WIDTH-1:0] ram_rdata;

    // A full FIFO is never empty (DEPTH >= 2), so a pop alongside a push at full
    // is always accepted and frees the slot the push needs.
    assign pop_ok  = bus.pop && !empty_q;
    assign push_ok = bus.push && (!full_q || bus.pop);
    assign op      = fifo_op_e'({push_ok, pop_ok});

    // NOTE: count_nxt takes its hold value first so every path assigns it and
    // no latch is inferred.
    always_comb begin
        count_nxt = count_q;
        unique case (op)
            OP_PUSH: count_nxt = count_q + CNT_W'(1);
            OP_POP:  count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (pop_ok) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            count_q        <= count_nxt;
            full_q         <= (count_nxt == CNT_W'(DEPTH));
            empty_q        <= (count_nxt == '0);
            almost_full_q  <= (count_nxt >= CNT_W'(AF_LEVEL));
            almost_empty_q <= (count_nxt <= CNT_W'(AE_LEVEL));
            overflow_q     <= bus.push && !push_ok;
            underflow_q    <= bus.pop && empty_q;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (bus.wdata),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign bus.rdata = ram_rdata;
    end else begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q <= '0;
            end else if (pop_ok) begin
                rdata_q <= ram_rdata;
            end
        end

        assign bus.rdata = rdata_q;
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_n_entry_fifo.sv
// Drives three FIFO configurations in lockstep and checks every output against a
// queue-based reference model after each clock edge.
module tb_sync_n_entry_fifo;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Configurations: 0 = DEPTH 4 FWFT, 1 = DEPTH 5 registered read, 2 = DEPTH 8 thresholds.
    int cfg_depth [3] = '{4, 5, 8};
    int cfg_af    [3] = '{3, 4, 6};
    int cfg_ae    [3] = '{1, 1, 2};
    int cfg_fwft  [3] = '{1, 0, 1};

    logic [7:0] mq    [3][$];
    logic [7:0] m_rd  [3];
    logic       m_ovf [3];
    logic       m_unf [3];

    sync_n_entry_fifo_if #(.WIDTH(8), .DEPTH(4)) if4 ();
    sync_n_entry_fifo_if #(.WIDTH(8), .DEPTH(5)) if5 ();
    sync_n_entry_fifo_if #(.WIDTH(8), .DEPTH(8)) if8 ();

    sync_n_entry_fifo #(
        .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    sync_n_entry_fifo #(
        .WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)
    ) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (if5)
    );

    sync_n_entry_fifo #(
        .WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic [7:0] rd, input logic e,
                             input logic f, input logic af, input logic ae,
                             input logic [31:0] cnt, input logic ov, input logic un);
        int sz;
        sz = mq[k].size();
        if (cfg_fwft[k] != 0) begin
            if (sz > 0) chk("rdata_fwft", k, 32'(rd), 32'(mq[k][0]));
        end else begin
            chk("rdata_reg", k, 32'(rd), 32'(m_rd[k]));
        end
        chk("count",        k, cnt,      32'(sz));
        chk("empty",        k, 32'(e),   32'(sz == 0));
        chk("full",         k, 32'(f),   32'(sz == cfg_depth[k]));
        chk("almost_full",  k, 32'(af),  32'(sz >= cfg_af[k]));
        chk("almost_empty", k, 32'(ae),  32'(sz <= cfg_ae[k]));
        chk("overflow",     k, 32'(ov),  32'(m_ovf[k]));
        chk("underflow",    k, 32'(un),  32'(m_unf[k]));
    endtask

    // One clock: drive, advance the model by the FIFO rules, then sample #1 after the edge.
    task automatic step(input logic p, input logic r, input logic [7:0] d, input logic rst);
        reset     = rst;
        if4.push  = p;  if5.push  = p;  if8.push  = p;
        if4.pop   = r;  if5.pop   = r;  if8.pop   = r;
        if4.wdata = d;  if5.wdata = d;  if8.wdata = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mq[k].delete();
                m_rd[k]  = 8'h00;
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end else begin
                int   sz;
                logic was_full, was_empty, pop_acc, push_acc;
                logic [7:0] head;
                sz        = mq[k].size();
                was_full  = (sz == cfg_depth[k]);
                was_empty = (sz == 0);
                pop_acc   = r && !was_empty;
                push_acc  = p && (!was_full || r);
                m_ovf[k]  = p && !push_acc;
                m_unf[k]  = r && was_empty;
                if (pop_acc) begin
                    head = mq[k].pop_front();
                    if (cfg_fwft[k] == 0) m_rd[k] = head;
                end
                if (push_acc) mq[k].push_back(d);
            end
        end
        #1;
        check_dut(0, if4.rdata, if4.empty, if4.full, if4.almost_full, if4.almost_empty,
                  32'(if4.count), if4.overflow, if4.underflow);
        check_dut(1, if5.rdata, if5.empty, if5.full, if5.almost_full, if5.almost_empty,
                  32'(if5.count), if5.overflow, if5.underflow);
        check_dut(2, if8.rdata, if8.empty, if8.full, if8.almost_full, if8.almost_empty,
                  32'(if8.count), if8.overflow, if8.underflow);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] fill_data [4];
        logic [7:0] d;
        logic p, r, rst;
        fill_data = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset overrides a simultaneous push and pop.
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("reset_empty", 0, 32'(if4.empty), 32'd1);
        chk("reset_rdata", 1, 32'(if5.rdata), 32'd0);

        // Fill and drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill_data[i], 1'b0);
        chk("fill_full",  0, 32'(if4.full),  32'd1);
        chk("fill_count", 0, 32'(if4.count), 32'd4);
        step(1'b1, 1'b0, 8'h55, 1'b0);
        chk("fill_overflow", 0, 32'(if4.overflow), 32'd1);
        chk("fill_count_held", 0, 32'(if4.count), 32'd4);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("overflow_one_cycle", 0, 32'(if4.overflow), 32'd0);
        chk("fill_head", 0, 32'(if4.rdata), 32'h11);
        drain(4);
        chk("drain_empty", 0, 32'(if4.empty), 32'd1);
        drain(6);

        // Empty with push+pop: pop rejected, push accepted.
        step(1'b1, 1'b1, 8'h66, 1'b0);
        chk("empty_pp_underflow", 2, 32'(if8.underflow), 32'd1);
        chk("empty_pp_count",     2, 32'(if8.count),     32'd1);

        // One entry standing, 12 push/pop pairs across the pointer wrap.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
        chk("wrap_count", 1, 32'(if5.count), 32'd1);
        drain(2);

        // Thresholds: step occupancy 0 -> 8 -> 0 (others saturate and overflow).
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        // Full with push+pop: head leaves, new word joins at the tail.
        step(1'b1, 1'b1, 8'hC3, 1'b0);
        chk("full_pp_count", 2, 32'(if8.count), 32'd8);
        drain(9);

        // Registered read: push 0xA5, pop, then hold through idle cycles.
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reg_rdata_hold", 1, 32'(if5.rdata), 32'hA5);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("reg_rdata_underflow_hold", 1, 32'(if5.rdata), 32'hA5);

        // Reset mid-operation with count = 3 and push+pop asserted.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b1);
        chk("midrst_count",    0, 32'(if4.count),     32'd0);
        chk("midrst_underflow", 0, 32'(if4.underflow), 32'd0);
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("midrst_restart", 1, 32'(if5.rdata), 32'h5A);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            p   = ($urandom_range(0, 99) < 55);
            r   = ($urandom_range(0, 99) < 45);
            d   = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step(p, r, d, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
